// File: rtl/mem_stage.sv
// Memory stage: registers execute results for writeback, turns loads and
// stores into data-bus requests and stalls upstream until the bus answers.

package common_pkg;
  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_LD     = 3'd3,
    OP_SD     = 3'd4
  } decoded_op_t;

  typedef struct packed {
    decoded_op_t op;
    logic        regwrite;
  } control_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    control_t        ctl;
    logic [4:0]      dst;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rd2;
  } excute_data_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    control_t        ctl;
    logic [4:0]      dst;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] addr;
  } memory_data_t;

  typedef struct packed {
    logic [4:0]      dst;
    logic [XLEN-1:0] data;
    logic            ismem;
  } tran_t;
endpackage

module mem_stage
  import common_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  excute_data_t ex_in,
  output logic         ex_ready,
  output logic         dreq_valid,
  output logic [63:0]  dreq_addr,
  output logic [2:0]   dreq_size,
  output logic [7:0]   dreq_strobe,
  output logic [63:0]  dreq_data,
  input  logic         dresp_data_ok,
  input  logic [63:0]  dresp_data,
  output memory_data_t mem_out,
  output tran_t        fwd,
  output logic         stall
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state;
  excute_data_t req;

  logic [1:0]  size;
  logic [2:0]  offset;
  logic        is_store;
  logic        unsigned_ld;
  logic [7:0]  size_mask;
  logic [63:0] lane;
  logic [63:0] load_data;
  logic        accept;
  logic        accept_mem;

  assign ex_ready   = (state == IDLE);
  assign stall      = ~ex_ready;
  assign accept     = ex_in.valid & ex_ready;
  assign accept_mem = (ex_in.ctl.op == OP_LD) | (ex_in.ctl.op == OP_SD);

  assign size        = req.instr[13:12];
  assign unsigned_ld = req.instr[14];
  assign offset      = req.result[2:0];
  assign is_store    = (req.ctl.op == OP_SD);

  // Request fields come straight from the buffered op so they stay stable until data_ok
  always_comb begin
    size_mask = 8'h00;
    case (size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    dreq_addr   = req.result;
    dreq_size   = {1'b0, size};
    dreq_strobe = is_store ? (size_mask << offset) : 8'h00;
    dreq_data   = req.rd2 << {offset, 3'b000};
  end

  // Shift the addressed bytes down to lane 0 and extend them to a full register
  always_comb begin
    lane      = dresp_data >> {offset, 3'b000};
    load_data = '0;
    case (size)
      2'd0:    load_data = unsigned_ld ? {56'b0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'd1:    load_data = unsigned_ld ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'd2:    load_data = unsigned_ld ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_data = lane;
    endcase
  end

  // Two-state handshake: pass non-memory ops through, park memory ops until the bus completes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mem_out    <= '0;
      dreq_valid <= 1'b0;
      req        <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_out.valid <= 1'b0;
          if (accept) begin
            if (accept_mem) begin
              req        <= ex_in;
              dreq_valid <= 1'b1;
              state      <= BUSY;
            end else begin
              mem_out.valid  <= 1'b1;
              mem_out.pc     <= ex_in.pc;
              mem_out.instr  <= ex_in.instr;
              mem_out.ctl    <= ex_in.ctl;
              mem_out.dst    <= ex_in.dst;
              mem_out.result <= ex_in.result;
              mem_out.addr   <= '0;
            end
          end
        end
        BUSY: begin
          mem_out.valid <= 1'b0;
          if (dresp_data_ok) begin
            mem_out.valid  <= 1'b1;
            mem_out.pc     <= req.pc;
            mem_out.instr  <= req.instr;
            mem_out.ctl    <= req.ctl;
            mem_out.dst    <= req.dst;
            mem_out.result <= is_store ? '0 : load_data;
            mem_out.addr   <= req.result;
            dreq_valid     <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bypass record seen by decode, derived from the registered result
  always_comb begin
    fwd.dst   = (mem_out.valid & mem_out.ctl.regwrite) ? mem_out.dst : 5'd0;
    fwd.data  = mem_out.result;
    fwd.ismem = mem_out.valid & (mem_out.ctl.op == OP_LD);
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the execute→memory pipeline handoff: accepts one excute_data_t per cycle and produces the registered memory_data_t for writeback.
- Non-memory ops pass through with one-cycle latency.
- LD/SD ops are turned into a data-bus request, and the stage stalls upstream until the bus returns data_ok.
- Also drives the tran_t forwarding record read by the decode-stage bypass logic.

Parameters:
- none (XLEN fixed at 64 by the common package)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low (reset==0 clears state on the clock edge)
- ex_in  input  excute_data_t  execute-stage output; valid bit qualifies it
- ex_ready  output  1  stage can accept ex_in this cycle
- dreq_valid  output  1  data-bus request valid
- dreq_addr  output  64  byte address, passed through unaligned
- dreq_size  output  3  0=1B, 1=2B, 2=4B, 3=8B
- dreq_strobe  output  8  byte-write enables; 0 means read
- dreq_data  output  64  lane-aligned store data
- dresp_data_ok  input  1  one-cycle pulse: request complete
- dresp_data  input  64  read data, full aligned doubleword
- mem_out  output  memory_data_t  registered result to writeback
- fwd  output  tran_t  forwarding record derived from mem_out
- stall  output  1  equals ~ex_ready; fed to the hazard unit

Behaviour:
- States: IDLE, BUSY. Reset → IDLE, mem_out all zero (valid=0), dreq_valid=0, request buffer zero.
- ex_ready = (state==IDLE). Accept = ex_in.valid & ex_ready.
- IDLE, accept, op∉{LD,SD}: next cycle mem_out = {pc, valid=1, instr, ctl, dst, result=ex_in.result, addr=0}; stay IDLE.
- IDLE, accept, op∈{LD,SD}:
  - Latch ex_in into the request buffer; go BUSY.
  - mem_out.valid=0 next cycle (bubble).
- IDLE, no accept: mem_out.valid=0 next cycle; other fields don't-care but hold.
- Request fields are driven from the buffer while BUSY:
  - dreq_valid=1 for every BUSY cycle.
  - Fields stay stable until data_ok.
  - addr = buffered ex_in.result; size = instr[13:12]; a = addr[2:0].
- SD:
  - strobe = ({1,3,15,255}[size] << a) truncated to 8 bits.
  - data = rd2 << (8*a).
- LD:
  - strobe = 0.
  - Response lane = dresp_data >> (8*a), truncated to size.
  - instr[14]=0: sign-extend to 64. instr[14]=1 (LBU/LHU/LWU): zero-extend.
- BUSY & dresp_data_ok:
  - Next cycle mem_out.valid=1, addr=request addr.
  - result = extended load data (LD) or 0 (SD).
  - state → IDLE.
  - ex_ready stays 0 during the data_ok cycle.
- BUSY without data_ok: hold all state; mem_out.valid=0. There is no timeout.
- dresp_data_ok in IDLE is ignored.
- Latency:
  - Non-mem ops: 1 cycle.
  - Mem ops: accepted at T, dreq_valid from T+1, data_ok at T+k (k≥1), mem_out valid at T+k+1, next accept possible at T+k+1.
- fwd (combinational from mem_out):
  - dst = (mem_out.valid & ctl.regwrite) ? mem_out.dst : 0.
  - data = mem_out.result.
  - ismem = mem_out.valid & (op==LD).
- Reset mid-BUSY: dreq_valid drops on that edge, state → IDLE, buffered request discarded. A later data_ok is ignored.
- Misaligned accesses are not checked; strobe and lanes are clipped to the addressed doubleword per the shift rules above.

Test Plan:
- Reset low 2 cycles, then ALU op (result=0x1234, dst=5, regwrite=1) → mem_out.valid=1 one cycle later, result=0x1234; fwd.dst=5, fwd.ismem=0.
- LD (LB, funct3=000), addr=0x1003; bus returns 0x00000000_80000000 after 3 cycles → dreq_size=0, strobe=0; ex_ready=0 for 4 cycles; mem_out.result=0xFFFFFFFF_FFFFFF80; fwd.ismem=1.
- LBU same stimulus → result=0x80. LWU addr=0x1004, data=0xF0000000_00000000 → result=0xF0000000.
- SH addr=0x2006, rd2=0xABCD → dreq_strobe=0xC0, dreq_data=0xABCD0000_00000000, size=1; fields stable across 5 wait cycles; result=0, addr=0x2006.
- Back-to-back: ADD, SD (data_ok after 1 cycle), ADD, all valid → second ADD held (ex_ready=0) until the cycle after data_ok; mem_out sequence ADD, bubble, SD, ADD.
- Reset asserted while BUSY, with data_ok arriving 2 cycles after release → dreq_valid=0 after the reset edge; mem_out.valid stays 0; the stray data_ok is ignored.
